// File: rtl/axis_tag_compactor_pkg.sv
// Purpose: shared tag type and lane-packing helpers for axis_tag_compactor.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package axis_tag_pkg;

  localparam int TAG_TIME_W = 64;
  localparam int TAG_CHAN_W = 6;
  localparam int MAX_LANES  = 32;

  typedef struct packed {
    logic [TAG_TIME_W-1:0] tag_time;
    logic [TAG_CHAN_W-1:0] chan;
  } tag_t;

  function automatic int popcount(input logic [MAX_LANES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) n += int'(v[i]);
    return n;
  endfunction

  // Dense slot a kept lane lands in: number of kept lanes below it.
  function automatic int lane_offset(input logic [MAX_LANES-1:0] keep, input int lane);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lane) n += int'(keep[i]);
    end
    return n;
  endfunction

  // +c -> c-1, -c -> nch+c-1; anything outside +-1..+-nch -> -1 (never enabled).
  function automatic int chan_mask_idx(input logic [TAG_CHAN_W-1:0] ch, input int nch);
    int c;
    c = int'($signed(ch));
    if (c >= 1 && c <= nch) return c - 1;
    if (c <= -1 && c >= -nch) return nch - c - 1;
    return -1;
  endfunction

endpackage

// File: rtl/axis_tag_compactor_lane_compress.sv
// Purpose: squeeze sparse input lanes into dense low lanes plus a kept-lane count.
// Latency: combinational.
// Backpressure: none; the caller decides whether the beat is accepted.
// Ports: i_tag/i_keep sparse lanes in; o_tag dense lanes (unused slots zero), o_cnt tags kept.
module tag_lane_compress
  import axis_tag_pkg::*;
#(
  parameter int IN_WORDS = 4
)(
  input  tag_t [IN_WORDS-1:0]           i_tag,
  input  logic [IN_WORDS-1:0]           i_keep,
  output tag_t [IN_WORDS-1:0]           o_tag,
  output logic [$clog2(IN_WORDS+1)-1:0] o_cnt
);

  localparam int IDX_W = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;

  always_comb begin
    int off;
    int pc;
    off   = 0;
    o_tag = '0;
    for (int i = 0; i < IN_WORDS; i++) begin
      off = lane_offset(MAX_LANES'(i_keep), i);
      if (i_keep[i]) o_tag[off[IDX_W-1:0]] = i_tag[i];
    end
    pc    = popcount(MAX_LANES'(i_keep));
    o_cnt = pc[$clog2(IN_WORDS+1)-1:0];
  end

endmodule

// File: rtl/axis_tag_compactor.sv
// Purpose: pack a sparse time-tag stream into dense OUT_WORDS beats, flushing partial words when idle.
// Latency: tags accepted in cycle N can appear on m_* in cycle N+1.
// Backpressure: s_tready depends only on registered occupancy/flush state; m_* hold while stalled.
// Ports: s_* sparse tag beats in, m_* dense tag beats out, m_lowest_time_bound = bound of unsent tags.
// Option: define AXIS_TAG_COMPACTOR_FILTER_EN to add chan_mask (per signed channel enable).
module axis_tag_compactor
  import axis_tag_pkg::*;
#(
  parameter int IN_WORDS      = 4,
  parameter int OUT_WORDS     = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int NUM_CHANNELS  = 18,
  parameter int BUF_DEPTH     = 16,
  parameter int FLUSH_CYCLES  = 64
)(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [IN_WORDS*TIME_WIDTH-1:0]    s_tagtime,
  input  logic [IN_WORDS*CHANNEL_WIDTH-1:0] s_channel,
  input  logic [IN_WORDS-1:0]               s_tkeep,
  input  logic [TIME_WIDTH-1:0]             s_lowest_time_bound,
`ifdef AXIS_TAG_COMPACTOR_FILTER_EN
  input  logic [2*NUM_CHANNELS-1:0]         chan_mask,
`endif
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [OUT_WORDS*TIME_WIDTH-1:0]   m_tagtime,
  output logic [OUT_WORDS*CHANNEL_WIDTH-1:0] m_channel,
  output logic [OUT_WORDS-1:0]              m_tkeep,
  output logic [TIME_WIDTH-1:0]             m_lowest_time_bound
);

  localparam int TW       = TIME_WIDTH;
  localparam int CW       = CHANNEL_WIDTH;
  localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int LCNT_W   = $clog2(IN_WORDS + 1);
  localparam int TMR_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  if (BUF_DEPTH < IN_WORDS + OUT_WORDS) begin : g_bad_depth
    $error("axis_tag_compactor: BUF_DEPTH must be >= IN_WORDS+OUT_WORDS");
  end
  if (TIME_WIDTH != TAG_TIME_W || CHANNEL_WIDTH != TAG_CHAN_W) begin : g_bad_width
    $error("axis_tag_compactor: tag widths must match axis_tag_pkg::tag_t");
  end
  if (IN_WORDS > MAX_LANES || NUM_CHANNELS >= (1 << (CHANNEL_WIDTH - 1))) begin : g_bad_lanes
    $error("axis_tag_compactor: IN_WORDS or NUM_CHANNELS out of range");
  end

  tag_t                  r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [CNT_W-1:0]      r_count;
  logic [TMR_W-1:0]      r_timer;
  logic                  r_flush;
  logic                  r_run;
  logic [TW-1:0]         r_bound;
  logic [TW-1:0]         r_src_bound;

  tag_t [IN_WORDS-1:0]   w_in_tag;
  tag_t [IN_WORDS-1:0]   w_dense;
  logic [IN_WORDS-1:0]   w_lane_en;
  logic [IN_WORDS-1:0]   w_keep;
  logic [LCNT_W-1:0]     w_lanes;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  int                    w_npush;
  int                    w_npop;
  logic [PTR_W-1:0]      w_head_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [TW-1:0]         w_bound_nxt;

  // Indices never exceed 2*BUF_DEPTH-1, so one conditional subtract wraps any depth.
  function automatic logic [PTR_W-1:0] f_wrap(input int a);
    int r;
    r = (a >= BUF_DEPTH) ? a - BUF_DEPTH : a;
    return r[PTR_W-1:0];
  endfunction

  always_comb begin
    w_in_tag = '0;
    for (int i = 0; i < IN_WORDS; i++) begin
      w_in_tag[i].tag_time = s_tagtime[i*TW +: TW];
      w_in_tag[i].chan     = s_channel[i*CW +: CW];
    end
  end

`ifdef AXIS_TAG_COMPACTOR_FILTER_EN
  localparam int MSK_W = $clog2(2 * NUM_CHANNELS);
  always_comb begin
    int idx;
    idx       = -1;
    w_lane_en = '0;
    for (int i = 0; i < IN_WORDS; i++) begin
      idx = chan_mask_idx(s_channel[i*CW +: CW], NUM_CHANNELS);
      if (idx >= 0) w_lane_en[i] = chan_mask[idx[MSK_W-1:0]];
    end
  end
`else
  assign w_lane_en = '1;
`endif

  assign w_keep = s_tkeep & w_lane_en;

  tag_lane_compress #(.IN_WORDS(IN_WORDS)) u_compress (
    .i_tag  (w_in_tag),
    .i_keep (w_keep),
    .o_tag  (w_dense),
    .o_cnt  (w_lanes)
  );

  assign w_full   = (r_count >= CNT_W'(OUT_WORDS));
  assign m_tvalid = w_full || r_flush;
  assign s_tready = r_run && !r_flush && ((CNT_W'(BUF_DEPTH) - r_count) >= CNT_W'(IN_WORDS));
  assign w_push   = s_tvalid && s_tready;
  assign w_pop    = m_tvalid && m_tready;

  always_comb begin
    int            v_cnt;
    int            v_rem;
    int            v_next;
    logic [TW-1:0] v_cand;
    v_cnt       = int'(r_count);
    w_npush     = w_push ? int'(w_lanes) : 0;
    w_npop      = w_pop ? (w_full ? OUT_WORDS : v_cnt) : 0;
    v_rem       = v_cnt - w_npop;
    v_next      = v_rem + w_npush;
    w_count_nxt = v_next[CNT_W-1:0];
    w_head_nxt  = f_wrap(int'(r_head) + w_npop);
    // Oldest surviving tag is either an old entry at the new head or, if all
    // old entries left this cycle, the first lane of the incoming beat.
    if (v_next != 0) v_cand = (v_rem != 0) ? r_buf[w_head_nxt].tag_time : w_dense[0].tag_time;
    else             v_cand = w_push ? s_lowest_time_bound : r_src_bound;
    w_bound_nxt = (v_cand > r_bound) ? v_cand : r_bound;
  end

  always_comb begin
    tag_t v_t;
    logic v_k;
    m_tkeep   = '0;
    m_tagtime = '0;
    m_channel = '0;
    for (int j = 0; j < OUT_WORDS; j++) begin
      v_k        = w_full || (r_flush && (int'(r_count) > j));
      v_t        = r_buf[f_wrap(int'(r_head) + j)];
      m_tkeep[j] = v_k;
      if (v_k) begin
        m_tagtime[j*TW +: TW] = v_t.tag_time;
        m_channel[j*CW +: CW] = v_t.chan;
      end
    end
  end

  assign m_lowest_time_bound = r_bound;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_head      <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_flush     <= 1'b0;
      r_bound     <= '0;
      r_src_bound <= '0;
    end else begin
      r_run   <= 1'b1;
      r_head  <= w_head_nxt;
      r_count <= w_count_nxt;
      r_bound <= w_bound_nxt;
      if (w_push) r_src_bound <= s_lowest_time_bound;
      if (w_pop) r_flush <= 1'b0;
      // Timer only runs while a partial word sits untouched.
      if (FLUSH_CYCLES == 0 || w_pop || w_npush != 0 || r_flush || r_count == '0 || w_full) begin
        r_timer <= '0;
      end else if (r_timer == TMR_LAST) begin
        r_timer <= '0;
        r_flush <= 1'b1;
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

  // Appends land behind the pre-pop tail, so a same-cycle pop never collides.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int j = 0; j < IN_WORDS; j++) begin
        if (j < int'(w_lanes)) r_buf[f_wrap(int'(r_head) + int'(r_count) + j)] <= w_dense[j];
      end
    end
  end

endmodule

// File: tb/tb_axis_tag_compactor.sv
module tb_axis_tag_compactor;

  localparam int IW = 4;
  localparam int OW = 4;
  localparam int TW = 64;
  localparam int CW = 6;
  localparam int NCH = 18;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                s_tvalid;
  logic                s_tready;
  logic [IW*TW-1:0]    s_tagtime;
  logic [IW*CW-1:0]    s_channel;
  logic [IW-1:0]       s_tkeep;
  logic [TW-1:0]       s_lowest_time_bound;
  logic                m_tvalid;
  logic                m_tready;
  logic [OW*TW-1:0]    m_tagtime;
  logic [OW*CW-1:0]    m_channel;
  logic [OW-1:0]       m_tkeep;
  logic [TW-1:0]       m_lowest_time_bound;
`ifdef AXIS_TAG_COMPACTOR_FILTER_EN
  logic [2*NCH-1:0]    chan_mask;
`endif

  int checks = 0;
  int errors = 0;
  logic [TW-1:0] q[$];

  always #5 clk = ~clk;

  axis_tag_compactor dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_tvalid            (s_tvalid),
    .s_tready            (s_tready),
    .s_tagtime           (s_tagtime),
    .s_channel           (s_channel),
    .s_tkeep             (s_tkeep),
    .s_lowest_time_bound (s_lowest_time_bound),
`ifdef AXIS_TAG_COMPACTOR_FILTER_EN
    .chan_mask           (chan_mask),
`endif
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready),
    .m_tagtime           (m_tagtime),
    .m_channel           (m_channel),
    .m_tkeep             (m_tkeep),
    .m_lowest_time_bound (m_lowest_time_bound)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [TW-1:0] t, input logic [CW-1:0] c);
    s_tagtime[i*TW +: TW] = t;
    s_channel[i*CW +: CW] = c;
  endtask

  task automatic set_beat(input logic [IW-1:0] keep, input logic [TW-1:0] base);
    for (int i = 0; i < IW; i++) set_lane(i, base + TW'(i), CW'(i + 1));
    s_tkeep  = keep;
    s_tvalid = 1'b1;
  endtask

  // Reference model: kept lanes of an accepted beat join the expected queue in lane order.
  task automatic note_push();
    if (s_tvalid && s_tready) begin
      for (int i = 0; i < IW; i++) if (s_tkeep[i]) q.push_back(s_tagtime[i*TW +: TW]);
    end
  endtask

  task automatic expect_head(input string tag);
    chk({tag, "_vld"}, 256'(m_tvalid), 256'(1));
    chk({tag, "_keep"}, 256'(m_tkeep), 256'(4'hF));
    for (int j = 0; j < OW; j++)
      chk($sformatf("%s_l%0d", tag, j), 256'(m_tagtime[j*TW +: TW]), 256'(q[j]));
  endtask

  task automatic expect_beat(input string tag);
    expect_head(tag);
    repeat (OW) void'(q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tkeep = '0;
    s_tagtime = '0;
    s_channel = '0;
    s_lowest_time_bound = '0;
    m_tready = 1'b0;
`ifdef AXIS_TAG_COMPACTOR_FILTER_EN
    chan_mask = '1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mvld", 256'(m_tvalid), 256'(0));
    chk("rst_mkeep", 256'(m_tkeep), 256'(0));
    chk("rst_mtime", 256'(m_tagtime), 256'(0));
    chk("rst_mchan", 256'(m_channel), 256'(0));
    chk("rst_bound", 256'(m_lowest_time_bound), 256'(0));
    chk("rst_srdy", 256'(s_tready), 256'(0));
    rst_n = 1'b1;
    step();
    step();
    chk("run_srdy", 256'(s_tready), 256'(1));

    // Sparse 0101 beats pack into two full words, in arrival order.
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_lane(0, TW'(1000 + 2*k), 6'd1);
      set_lane(1, 64'd9999, 6'd7);
      set_lane(2, TW'(1001 + 2*k), 6'd2);
      set_lane(3, 64'd9999, 6'd7);
      s_tkeep  = 4'b0101;
      s_tvalid = 1'b1;
      note_push();
      step();
      if (k == 0) chk("pk_b0_vld", 256'(m_tvalid), 256'(0));
      if (k == 1) begin
        chk("pk_w0_chan", 256'(m_channel), 256'({6'd2, 6'd1, 6'd2, 6'd1}));
        expect_beat("pk_w0");
      end
      if (k == 2) chk("pk_b2_vld", 256'(m_tvalid), 256'(0));
      if (k == 3) expect_beat("pk_w1");
    end
    s_tvalid = 1'b0;
    step();
    chk("pk_empty_vld", 256'(m_tvalid), 256'(0));

    // Lone tag flushes after the idle timeout and stalls input until taken.
    m_tready = 1'b0;
    set_lane(0, 64'd1000, 6'd5);
    s_tkeep  = 4'b0001;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    s_tkeep  = '0;
    repeat (63) step();
    chk("fl_early_vld", 256'(m_tvalid), 256'(0));
    step();
    chk("fl_vld", 256'(m_tvalid), 256'(1));
    chk("fl_keep", 256'(m_tkeep), 256'(4'b0001));
    chk("fl_time", 256'(m_tagtime[TW-1:0]), 256'(1000));
    chk("fl_hi_zero", 256'(m_tagtime[OW*TW-1:TW]), 256'(0));
    chk("fl_srdy", 256'(s_tready), 256'(0));
    repeat (3) step();
    chk("fl_hold_vld", 256'(m_tvalid), 256'(1));
    chk("fl_hold_time", 256'(m_tagtime[TW-1:0]), 256'(1000));
    chk("fl_hold_srdy", 256'(s_tready), 256'(0));
    m_tready = 1'b1;
    step();
    chk("fl_done_vld", 256'(m_tvalid), 256'(0));
    chk("fl_done_srdy", 256'(s_tready), 256'(1));

    // Stall with full input every cycle: four beats fit, then input stops.
    m_tready = 1'b0;
    nb = 0;
    for (int k = 0; k < 6; k++) begin
      set_beat(4'hF, TW'(2000 + 4*k));
      if (s_tready) nb++;
      note_push();
      step();
    end
    chk("st_naccept", 256'(nb), 256'(4));
    chk("st_srdy", 256'(s_tready), 256'(0));
    for (int r = 0; r < 3; r++) begin
      expect_head($sformatf("st_hold%0d", r));
      note_push();
      step();
    end
    // Drain to count 8, then push+pop together; head wraps past the top.
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    expect_beat("st_d0");
    step();
    expect_beat("st_d1");
    step();
    for (int k = 0; k < 3; k++) begin
      set_beat(4'hF, TW'(3000 + 4*k));
      chk($sformatf("st_pp%0d_srdy", k), 256'(s_tready), 256'(1));
      expect_beat($sformatf("st_pp%0d", k));
      note_push();
      step();
    end
    s_tvalid = 1'b0;
    expect_beat("st_e0");
    step();
    expect_beat("st_e1");
    step();
    chk("st_final_vld", 256'(m_tvalid), 256'(0));
    chk("st_q_empty", 256'(q.size()), 256'(0));

    // Time bound: source bound when empty, oldest tag while buffered, never falls.
    s_tkeep  = '0;
    s_lowest_time_bound = 64'd5000;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("tb_src", 256'(m_lowest_time_bound), 256'(5000));
    m_tready = 1'b0;
    set_lane(0, 64'd6000, 6'd1);
    s_tkeep  = 4'b0001;
    s_lowest_time_bound = 64'd5500;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("tb_tag", 256'(m_lowest_time_bound), 256'(6000));
    repeat (2) step();
    chk("tb_tag_hold", 256'(m_lowest_time_bound), 256'(6000));
    set_lane(0, 64'd6001, 6'd1);
    set_lane(1, 64'd6002, 6'd1);
    set_lane(2, 64'd6003, 6'd1);
    s_tkeep  = 4'b0111;
    s_lowest_time_bound = 64'd5600;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("tb_full_vld", 256'(m_tvalid), 256'(1));
    chk("tb_full_l0", 256'(m_tagtime[TW-1:0]), 256'(6000));
    chk("tb_full_l3", 256'(m_tagtime[4*TW-1:3*TW]), 256'(6003));
    chk("tb_full_bound", 256'(m_lowest_time_bound), 256'(6000));
    m_tready = 1'b1;
    step();
    chk("tb_sent_vld", 256'(m_tvalid), 256'(0));
    chk("tb_sent_mono", 256'(m_lowest_time_bound), 256'(6000));
    s_tkeep  = '0;
    s_lowest_time_bound = 64'd7000;
    s_tvalid = 1'b1;
    step();
    chk("tb_rise", 256'(m_lowest_time_bound), 256'(7000));
    s_lowest_time_bound = 64'd6500;
    step();
    s_tvalid = 1'b0;
    chk("tb_nofall", 256'(m_lowest_time_bound), 256'(7000));

    // Mid-stream reset drops buffered tags immediately.
    m_tready = 1'b0;
    set_beat(4'hF, 64'd9000);
    step();
    s_tvalid = 1'b0;
    chk("mr_pre_vld", 256'(m_tvalid), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_vld", 256'(m_tvalid), 256'(0));
    chk("mr_keep", 256'(m_tkeep), 256'(0));
    chk("mr_srdy", 256'(s_tready), 256'(0));
    chk("mr_bound", 256'(m_lowest_time_bound), 256'(0));
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("mr_after_vld", 256'(m_tvalid), 256'(0));
    chk("mr_after_srdy", 256'(s_tready), 256'(1));
    set_beat(4'hF, 64'd9100);
    step();
    s_tvalid = 1'b0;
    chk("mr_new_vld", 256'(m_tvalid), 256'(1));
    chk("mr_new_l0", 256'(m_tagtime[TW-1:0]), 256'(9100));
    chk("mr_new_l3", 256'(m_tagtime[4*TW-1:3*TW]), 256'(9103));
    m_tready = 1'b1;
    step();
    chk("mr_new_done", 256'(m_tvalid), 256'(0));

`ifdef AXIS_TAG_COMPACTOR_FILTER_EN
    // Only +3 enabled: lanes carrying -3 and +1 vanish.
    chan_mask = '0;
    chan_mask[2] = 1'b1;
    m_tready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_lane(0, TW'(8000 + 4*k), 6'd3);
      set_lane(1, TW'(8001 + 4*k), 6'b111101);
      set_lane(2, TW'(8002 + 4*k), 6'd1);
      set_lane(3, TW'(8003 + 4*k), 6'd3);
      s_tkeep  = 4'hF;
      s_tvalid = 1'b1;
      step();
      if (k == 0) chk("flt_half_vld", 256'(m_tvalid), 256'(0));
    end
    s_tvalid = 1'b0;
    chk("flt_vld", 256'(m_tvalid), 256'(1));
    chk("flt_l0", 256'(m_tagtime[TW-1:0]), 256'(8000));
    chk("flt_l1", 256'(m_tagtime[2*TW-1:TW]), 256'(8003));
    chk("flt_l2", 256'(m_tagtime[3*TW-1:2*TW]), 256'(8004));
    chk("flt_l3", 256'(m_tagtime[4*TW-1:3*TW]), 256'(8007));
    chk("flt_chan", 256'(m_channel), 256'({6'd3, 6'd3, 6'd3, 6'd3}));
    m_tready = 1'b1;
    step();
    chk("flt_done", 256'(m_tvalid), 256'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
